exc_sequencer: RTL and testbench

- Exception entry/return controller for the CPSR/SPSR bank.
- Arbitrates pending FIQ, IRQ, SVC (SWI) and UND requests at instruction boundaries.
- Sequences the bank's control strobes (Change_M, W_SPSR_s, Write_SPSR, W_CPSR_s, Write_CPSR) through a fixed multi-cycle entry, and a single-cycle SPSR->CPSR restore on exception return.
- Drives LR/PC writes and stalls the core while sequencing. Sits between the core control unit and the CPSR bank.

---
 rtl/exc_sequencer_pkg.sv | 82 ++++++++
 rtl/exc_sequencer_if.sv | 39 +++
 rtl/exc_prio_arb.sv | 34 +++
 rtl/exc_sequencer.sv | 132 +++++++++++++
 tb/tb_exc_sequencer.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/exc_sequencer_pkg.sv
// Shared definitions for the exception entry/return sequencer.
// Holds the FSM state codes, the exception target type, the CPSR bank
// strobe encodings, the vector offsets and the CPSR mask bit positions,
// plus small helpers that map a target to its encodings.
package exc_sequencer_pkg;

  // FSM state codes
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SAVE   = 3'd1;
  localparam logic [2:0] ST_SWITCH = 3'd2;
  localparam logic [2:0] ST_LINK   = 3'd3;
  localparam logic [2:0] ST_RETURN = 3'd4;

  typedef enum logic [1:0] {
    ExcFiq,
    ExcIrq,
    ExcUnd,
    ExcSvc
  } exc_e;

  // Change_M encodings
  localparam logic [2:0] CM_CUR = 3'd0;
  localparam logic [2:0] CM_FIQ = 3'd1;
  localparam logic [2:0] CM_IRQ = 3'd2;
  localparam logic [2:0] CM_SVC = 3'd3;
  localparam logic [2:0] CM_UND = 3'd4;

  // W_CPSR_s encodings (CS_NEW is reserved by the bank, never driven here)
  localparam logic [2:0] CS_SPSR = 3'd0;
  localparam logic [2:0] CS_NEW  = 3'd1;
  localparam logic [2:0] CS_IRQ  = 3'd2;
  localparam logic [2:0] CS_FIQ  = 3'd3;
  localparam logic [2:0] CS_SVC  = 3'd4;
  localparam logic [2:0] CS_UND  = 3'd5;

  // Vector offsets from the vector base
  localparam logic [31:0] VEC_UND = 32'h0000_0004;
  localparam logic [31:0] VEC_SVC = 32'h0000_0008;
  localparam logic [31:0] VEC_IRQ = 32'h0000_0018;
  localparam logic [31:0] VEC_FIQ = 32'h0000_001C;

  // CPSR mask bits
  localparam int unsigned I_BIT = 7;
  localparam int unsigned F_BIT = 6;

  function automatic logic [2:0] cm_code(exc_e e);
    logic [2:0] r;
    r = CM_FIQ;
    unique case (e)
      ExcFiq: r = CM_FIQ;
      ExcIrq: r = CM_IRQ;
      ExcUnd: r = CM_UND;
      ExcSvc: r = CM_SVC;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] cs_code(exc_e e);
    logic [2:0] r;
    r = CS_FIQ;
    unique case (e)
      ExcFiq: r = CS_FIQ;
      ExcIrq: r = CS_IRQ;
      ExcUnd: r = CS_UND;
      ExcSvc: r = CS_SVC;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] vec_ofs(exc_e e);
    logic [31:0] r;
    r = VEC_FIQ;
    unique case (e)
      ExcFiq: r = VEC_FIQ;
      ExcIrq: r = VEC_IRQ;
      ExcUnd: r = VEC_UND;
      ExcSvc: r = VEC_SVC;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/exc_sequencer_if.sv
// Bundle between the core control unit, the exception sequencer and the
// CPSR bank. Requests/addresses flow into the sequencer; bank strobes,
// LR/PC writes, stall and exc_ack flow out of it.
//   master : the sequencer side (requests in, strobes out)
//   slave  : the core/bank side (requests out, strobes in)
interface exc_sequencer_if;
  logic        irq;
  logic        fiq;
  logic        swi_req;
  logic        und_req;
  logic        eret_req;
  logic [31:0] eret_target;
  logic        inst_boundary;
  logic [31:0] ret_addr;
  logic [31:0] cpsr_i;
  logic        stall;
  logic [2:0]  Change_M;
  logic        W_SPSR_s;
  logic        Write_SPSR;
  logic [2:0]  W_CPSR_s;
  logic        Write_CPSR;
  logic        lr_we;
  logic [31:0] lr_data;
  logic        pc_we;
  logic [31:0] pc_data;
  logic        exc_ack;

  modport master (
    input  irq, fiq, swi_req, und_req, eret_req, eret_target, inst_boundary, ret_addr, cpsr_i,
    output stall, Change_M, W_SPSR_s, Write_SPSR, W_CPSR_s, Write_CPSR, lr_we, lr_data, pc_we,
           pc_data, exc_ack
  );

  modport slave (
    output irq, fiq, swi_req, und_req, eret_req, eret_target, inst_boundary, ret_addr, cpsr_i,
    input  stall, Change_M, W_SPSR_s, Write_SPSR, W_CPSR_s, Write_CPSR, lr_we, lr_data, pc_we,
           pc_data, exc_ack
  );
endinterface

// File: rtl/exc_prio_arb.sv
// Combinational priority/mask arbiter for pending exceptions.
// Ports: fiq/irq live requests, f_mask/i_mask CPSR mask bits, und_pend/swi_pend
// sticky flags; valid = something is eligible, target = winner.
// Priority FIQ > IRQ > UND > SVC.
module exc_prio_arb
  import exc_sequencer_pkg::*;
(
  input  logic fiq,
  input  logic irq,
  input  logic f_mask,
  input  logic i_mask,
  input  logic und_pend,
  input  logic swi_pend,
  output logic valid,
  output exc_e target
);

  always_comb begin
    valid  = 1'b1;
    target = ExcFiq;
    if (fiq && !f_mask) begin
      target = ExcFiq;
    end else if (irq && !i_mask) begin
      target = ExcIrq;
    end else if (und_pend) begin
      target = ExcUnd;
    end else if (swi_pend) begin
      target = ExcSvc;
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/exc_sequencer.sv
// Exception entry/return sequencer for the CPSR/SPSR bank.
// Ports: clk, rst (synchronous, active-high), bus (exc_sequencer_if.master).
// Entry: IDLE -> SAVE (CPSR->SPSR) -> SWITCH (new CPSR) -> LINK (LR/PC write).
// Return: IDLE -> RETURN (SPSR->CPSR, PC = eret_target).
// Outputs decode registered state only, so they are settled before the
// bank's falling-edge write; rst forces them low in the same cycle.
module exc_sequencer
  import exc_sequencer_pkg::*;
#(
  parameter logic [31:0] VEC_BASE   = 32'h0000_0000,
  parameter logic [31:0] IRQ_LR_OFS = 32'd4
) (
  input logic             clk,
  input logic             rst,
  exc_sequencer_if.master bus
);

  logic [2:0]  state_q, state_d;
  exc_e        tgt_q, tgt_d;
  logic [31:0] addr_q, addr_d;  // ret_addr on entry, eret_target on return
  logic        swi_pend_q, swi_pend_d;
  logic        und_pend_q, und_pend_d;
  logic        arb_valid;
  exc_e        arb_tgt;
  logic        take_ret, take_exc;
  logic        unused_cpsr;

  assign unused_cpsr = ^{bus.cpsr_i[31:8], bus.cpsr_i[5:0]};

  exc_prio_arb u_arb (
    .fiq      (bus.fiq),
    .irq      (bus.irq),
    .f_mask   (bus.cpsr_i[F_BIT]),
    .i_mask   (bus.cpsr_i[I_BIT]),
    .und_pend (und_pend_q),
    .swi_pend (swi_pend_q),
    .valid    (arb_valid),
    .target   (arb_tgt)
  );

  always_comb begin
    take_ret = (state_q == ST_IDLE) && bus.inst_boundary && bus.eret_req;
    take_exc = (state_q == ST_IDLE) && bus.inst_boundary && !bus.eret_req && arb_valid;
    state_d  = state_q;
    tgt_d    = tgt_q;
    addr_d   = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (take_ret) begin
          state_d = ST_RETURN;
          addr_d  = bus.eret_target;
        end else if (take_exc) begin
          state_d = ST_SAVE;
          tgt_d   = arb_tgt;
          addr_d  = bus.ret_addr;
        end
      end
      ST_SAVE:   state_d = ST_SWITCH;
      ST_SWITCH: state_d = ST_LINK;
      ST_LINK:   state_d = ST_IDLE;
      ST_RETURN: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    // A new pulse in the same cycle the old one is taken stays pending.
    swi_pend_d = bus.swi_req | (swi_pend_q & ~(take_exc && (arb_tgt == ExcSvc)));
    und_pend_d = bus.und_req | (und_pend_q & ~(take_exc && (arb_tgt == ExcUnd)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tgt_q      <= ExcFiq;
      addr_q     <= 32'h0;
      swi_pend_q <= 1'b0;
      und_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      addr_q     <= addr_d;
      swi_pend_q <= swi_pend_d;
      und_pend_q <= und_pend_d;
    end
  end

  always_comb begin
    bus.stall      = 1'b0;
    bus.Change_M   = CM_CUR;
    bus.W_SPSR_s   = 1'b0;
    bus.Write_SPSR = 1'b0;
    bus.W_CPSR_s   = CS_SPSR;
    bus.Write_CPSR = 1'b0;
    bus.lr_we      = 1'b0;
    bus.lr_data    = 32'h0;
    bus.pc_we      = 1'b0;
    bus.pc_data    = 32'h0;
    bus.exc_ack    = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_SAVE: begin
          bus.stall      = 1'b1;
          bus.Change_M   = cm_code(tgt_q);
          bus.W_SPSR_s   = 1'b1;
          bus.Write_SPSR = 1'b1;
        end
        ST_SWITCH: begin
          bus.stall      = 1'b1;
          bus.Change_M   = cm_code(tgt_q);
          bus.W_CPSR_s   = cs_code(tgt_q);
          bus.Write_CPSR = 1'b1;
        end
        ST_LINK: begin
          bus.stall   = 1'b1;
          bus.lr_we   = 1'b1;
          bus.lr_data = addr_q +
                        (((tgt_q == ExcFiq) || (tgt_q == ExcIrq)) ? IRQ_LR_OFS : 32'h0);
          bus.pc_we   = 1'b1;
          bus.pc_data = VEC_BASE + vec_ofs(tgt_q);
          bus.exc_ack = 1'b1;
        end
        ST_RETURN: begin
          bus.stall      = 1'b1;
          bus.W_CPSR_s   = CS_SPSR;
          bus.Write_CPSR = 1'b1;
          bus.pc_we      = 1'b1;
          bus.pc_data    = addr_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_sequencer.sv
// Bench for exc_sequencer: a queue-based reference model predicts each
// cycle's outputs for two instances (vector base 0 and 0xFFFF0000),
// plus directed scenarios with literal expectations, then random traffic.
module tb_exc_sequencer;

  typedef struct packed {
    logic        stall;
    logic [2:0]  cm;
    logic        wss;
    logic        ws;
    logic [2:0]  cs;
    logic        wc;
    logic        lrwe;
    logic [31:0] lrd;
    logic        pcwe;
    logic [31:0] pcd;
    logic        ack;
  } out_t;

  localparam logic [31:0] BASE_HI = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        irq, fiq, swi_req, und_req, eret_req, inst_boundary;
  logic [31:0] eret_target, ret_addr, cpsr;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  exc_sequencer_if bus0 ();
  exc_sequencer_if bus1 ();

  assign bus0.irq = irq;             assign bus1.irq = irq;
  assign bus0.fiq = fiq;             assign bus1.fiq = fiq;
  assign bus0.swi_req = swi_req;     assign bus1.swi_req = swi_req;
  assign bus0.und_req = und_req;     assign bus1.und_req = und_req;
  assign bus0.eret_req = eret_req;   assign bus1.eret_req = eret_req;
  assign bus0.eret_target = eret_target; assign bus1.eret_target = eret_target;
  assign bus0.inst_boundary = inst_boundary; assign bus1.inst_boundary = inst_boundary;
  assign bus0.ret_addr = ret_addr;   assign bus1.ret_addr = ret_addr;
  assign bus0.cpsr_i = cpsr;         assign bus1.cpsr_i = cpsr;

  exc_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  exc_sequencer #(
    .VEC_BASE (BASE_HI)
  ) dut_hi (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Exceptions: 0 fiq, 1 irq, 2 und, 3 svc. Each queue entry is one cycle
  // of expected outputs; an empty queue means idle.
  out_t q0[$];
  out_t q1[$];
  logic swi_p = 1'b0, und_p = 1'b0;
  int   m_e;

  function automatic logic [2:0] m_cm(int e);
    case (e) 0: return 3'd1; 1: return 3'd2; 2: return 3'd4; default: return 3'd3; endcase
  endfunction
  function automatic logic [2:0] m_cs(int e);
    case (e) 0: return 3'd3; 1: return 3'd2; 2: return 3'd5; default: return 3'd4; endcase
  endfunction
  function automatic logic [31:0] m_ofs(int e);
    case (e) 0: return 32'h1C; 1: return 32'h18; 2: return 32'h04; default: return 32'h08; endcase
  endfunction

  task automatic push_entry(int e, logic [31:0] r);
    out_t s;
    s = '0; s.stall = 1; s.cm = m_cm(e); s.wss = 1; s.ws = 1;
    q0.push_back(s); q1.push_back(s);
    s = '0; s.stall = 1; s.cm = m_cm(e); s.cs = m_cs(e); s.wc = 1;
    q0.push_back(s); q1.push_back(s);
    s = '0; s.stall = 1; s.lrwe = 1; s.pcwe = 1; s.ack = 1;
    s.lrd = r + ((e < 2) ? 32'd4 : 32'd0);
    s.pcd = m_ofs(e);
    q0.push_back(s);
    s.pcd = BASE_HI + m_ofs(e);
    q1.push_back(s);
  endtask

  task automatic push_ret(logic [31:0] t);
    out_t s;
    s = '0; s.stall = 1; s.wc = 1; s.pcwe = 1; s.pcd = t;
    q0.push_back(s); q1.push_back(s);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      q0.delete(); q1.delete(); swi_p = 0; und_p = 0;
    end else begin
      m_e = -1;
      if (q0.size() != 0) begin
        void'(q0.pop_front()); void'(q1.pop_front());
      end else if (inst_boundary) begin
        if (eret_req) push_ret(eret_target);
        else if (fiq && !cpsr[6]) m_e = 0;
        else if (irq && !cpsr[7]) m_e = 1;
        else if (und_p) m_e = 2;
        else if (swi_p) m_e = 3;
        if (m_e >= 0) push_entry(m_e, ret_addr);
      end
      swi_p = swi_req | (swi_p & (m_e != 3));
      und_p = und_req | (und_p & (m_e != 2));
    end
  end

  // ---------------- per-cycle compare ----------------
  out_t exp0, exp1, act0, act1;
  always @(negedge clk) begin
    if (chk_en) begin
      exp0 = (rst || q0.size() == 0) ? '0 : q0[0];
      exp1 = (rst || q1.size() == 0) ? '0 : q1[0];
      act0 = {bus0.stall, bus0.Change_M, bus0.W_SPSR_s, bus0.Write_SPSR, bus0.W_CPSR_s,
              bus0.Write_CPSR, bus0.lr_we, bus0.lr_data, bus0.pc_we, bus0.pc_data, bus0.exc_ack};
      act1 = {bus1.stall, bus1.Change_M, bus1.W_SPSR_s, bus1.Write_SPSR, bus1.W_CPSR_s,
              bus1.Write_CPSR, bus1.lr_we, bus1.lr_data, bus1.pc_we, bus1.pc_data, bus1.exc_ack};
      checks++;
      if (act0 !== exp0) begin
        failures++;
        $display("FAIL model_outputs_base0 t=%0t got=%h want=%h", $time, act0, exp0);
      end
      checks++;
      if (act1 !== exp1) begin
        failures++;
        $display("FAIL model_outputs_basehi t=%0t got=%h want=%h", $time, act1, exp1);
      end
    end
  end

  // ---------------- directed literal checks ----------------
  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, expv);
    end
  endtask

  // Caller leaves inputs set while idle; the next posedge takes the entry.
  task automatic entry_check(string nm, logic [2:0] cm, logic [2:0] cs, logic [31:0] lr,
                             logic [31:0] pc, logic [31:0] pc2);
    @(posedge clk); #1;
    irq = 0; fiq = 0; swi_req = 0; und_req = 0; ret_addr = 32'hDEAD_BEEF;
    @(negedge clk);
    chk({nm, "_save_stall"}, 32'(bus0.stall), 32'd1);
    chk({nm, "_save_cm"}, 32'(bus0.Change_M), 32'(cm));
    chk({nm, "_save_wspsr"}, 32'({bus0.Write_SPSR, bus0.W_SPSR_s}), 32'd3);
    @(negedge clk);
    chk({nm, "_switch_cs"}, 32'(bus0.W_CPSR_s), 32'(cs));
    chk({nm, "_switch_wcpsr"}, 32'(bus0.Write_CPSR), 32'd1);
    @(negedge clk);
    chk({nm, "_link_lr"}, bus0.lr_data, lr);
    chk({nm, "_link_pc"}, bus0.pc_data, pc);
    chk({nm, "_link_pc_hi"}, bus1.pc_data, pc2);
    chk({nm, "_link_ack"}, 32'({bus0.exc_ack, bus0.lr_we, bus0.pc_we, bus0.Change_M}), 32'h38);
    @(negedge clk);
    chk({nm, "_stall_end"}, 32'(bus0.stall), 32'd0);
  endtask

  initial begin
    rst = 1; irq = 1; fiq = 0; swi_req = 0; und_req = 0; eret_req = 0; inst_boundary = 1;
    eret_target = 0; ret_addr = 32'h100; cpsr = 32'h10;
    @(posedge clk); #1 chk_en = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'({bus0.stall, bus0.Change_M, bus0.Write_SPSR, bus0.Write_CPSR}), 0);
    chk("reset_pc", bus0.pc_data, 32'h0);

    // IRQ held through reset, taken right after release
    @(posedge clk); #1 rst = 0;
    entry_check("irq", 3'd2, 3'd2, 32'h104, 32'h18, 32'hFFFF_0018);

    // FIQ beats IRQ; with F masked IRQ wins
    irq = 1; fiq = 1; cpsr = 32'h10; ret_addr = 32'h200;
    entry_check("fiq", 3'd1, 3'd3, 32'h204, 32'h1C, 32'hFFFF_001C);
    irq = 1; fiq = 1; cpsr = 32'h50; ret_addr = 32'h300;
    entry_check("fmask_irq", 3'd2, 3'd2, 32'h304, 32'h18, 32'hFFFF_0018);

    // SWI held while not at a boundary
    cpsr = 32'hD0; inst_boundary = 0; swi_req = 1; ret_addr = 32'h400;
    @(posedge clk); #1 swi_req = 0;
    @(posedge clk);
    @(negedge clk);
    chk("swi_held_no_stall", 32'(bus0.stall), 32'd0);
    inst_boundary = 1;
    entry_check("svc", 3'd3, 3'd4, 32'h400, 32'h08, 32'hFFFF_0008);

    // eret beats IRQ; IRQ only after the restored mask clears
    cpsr = 32'h10; irq = 1; eret_req = 1; eret_target = 32'h204; ret_addr = 32'h500;
    @(posedge clk); #1 eret_req = 0; cpsr = 32'h90;
    @(negedge clk);
    chk("ret_wcpsr", 32'({bus0.stall, bus0.Write_CPSR, bus0.W_CPSR_s, bus0.Change_M}), 32'hC0);
    chk("ret_pc", bus0.pc_data, 32'h204);
    chk("ret_pcwe_lrwe", 32'({bus0.pc_we, bus0.lr_we}), 32'd2);
    @(negedge clk);
    chk("ret_done", 32'(bus0.stall), 32'd0);
    @(negedge clk);
    chk("irq_masked_after_ret", 32'(bus0.stall), 32'd0);
    cpsr = 32'h10;
    entry_check("irq_after_ret", 3'd2, 3'd2, 32'h504, 32'h18, 32'hFFFF_0018);

    // LR adder wraps
    fiq = 1; ret_addr = 32'hFFFF_FFFE;
    entry_check("wrap", 3'd1, 3'd3, 32'h2, 32'h1C, 32'hFFFF_001C);

    // UND taken, second UND pending, reset in SWITCH clears everything
    und_req = 1;
    @(posedge clk); #1 und_req = 0;
    @(posedge clk); #1 und_req = 1;
    @(posedge clk); #1 und_req = 0; rst = 1;
    @(negedge clk);
    chk("rst_mid_strobes", 32'({bus0.stall, bus0.Write_CPSR, bus0.W_CPSR_s, bus0.Change_M}), 0);
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_clears_und", 32'({bus0.stall, bus0.lr_we, bus0.pc_we}), 32'd0);
    end

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      rst           = ($urandom_range(0, 99) == 0);
      irq           = ($urandom_range(0, 3) == 0);
      fiq           = ($urandom_range(0, 7) == 0);
      swi_req       = ($urandom_range(0, 15) == 0);
      und_req       = ($urandom_range(0, 15) == 0);
      eret_req      = ($urandom_range(0, 19) == 0);
      inst_boundary = ($urandom_range(0, 3) != 0);
      cpsr          = $urandom;
      eret_target   = $urandom;
      ret_addr      = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                  : $urandom;
    end
    @(posedge clk); #1 rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
